// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the AXI4-Lite master/slave pair.
//   ADDR_W / DATA_W : bus widths
//   NUM_REGS, IDX_W : register count and word-index width (bits [ADDR_W-1:2])
//   RESP_*          : AXI response codes
//   wr_state_e, rd_state_e : channel FSM states
package axi4_lite_pkg;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 32;
  localparam int IDX_W    = ADDR_W - 2;
  localparam int NUM_REGS = 1 << IDX_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;
endpackage

// File: rtl/axi4_lite_slave_if.sv
// AXI4-Lite channel bundle (AW, W, B, AR, R).
//   master modport : drives addresses, data, VALIDs and BREADY/RREADY
//   slave  modport : drives AWREADY/WREADY/ARREADY, responses and read data
// Handshake: a transfer happens on a rising ACLK edge where VALID and READY
// are both high; VALID, once raised, is held with its payload until that edge,
// and no READY is ever a combinational function of its VALID.
interface axi4_lite_slave_if;
  import axi4_lite_pkg::*;

  logic [ADDR_W-1:0] AWADDR;
  logic              AWVALID;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic              WVALID;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic              ARVALID;
  logic              ARREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi4_lite_regfile.sv
// Bank of NUM_REGS x DATA_W registers.
//   clk, rst_n : clock, asynchronous active-low reset (clears all registers)
//   we, waddr, wdata : synchronous write port
//   raddr -> rdata   : combinational read port (returns pre-edge contents)
//   regs             : all register contents in parallel
module axi4_lite_regfile
  import axi4_lite_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             we,
  input  logic [IDX_W-1:0]                 waddr,
  input  logic [DATA_W-1:0]                wdata,
  input  logic [IDX_W-1:0]                 raddr,
  output logic [DATA_W-1:0]                rdata,
  output logic [NUM_REGS-1:0][DATA_W-1:0]  regs
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata = regs[raddr];
endmodule

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite slave terminating AW/W/B and AR/R over four 32-bit registers.
//   ACLK, ARESETn  : clock, asynchronous active-low reset
//   bus            : AXI4-Lite channels (slave modport)
//   slv_reg0..3    : register contents
//   wr_state_dbg, rd_state_dbg : current channel FSM states
module axi4_lite_slave
  import axi4_lite_pkg::*;
(
  input  logic                ACLK,
  input  logic                ARESETn,
  axi4_lite_slave_if.slave    bus,
  output logic [DATA_W-1:0]   slv_reg0,
  output logic [DATA_W-1:0]   slv_reg1,
  output logic [DATA_W-1:0]   slv_reg2,
  output logic [DATA_W-1:0]   slv_reg3,
  output wr_state_e           wr_state_dbg,
  output rd_state_e           rd_state_dbg
);
  wr_state_e wr_state, wr_next;
  rd_state_e rd_state, rd_next;

  // Holds every READY low during reset and releases them one edge later.
  logic ready_en;

  logic             aw_got, w_got;
  logic [IDX_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic aw_ready, w_ready, b_valid, do_write, aw_hs, w_hs;
  logic ar_ready, r_valid, ar_hs;

  logic [IDX_W-1:0]  reg_waddr;
  logic [DATA_W-1:0] reg_wdata, reg_rdata;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;

  // Byte-offset bits are don't-care for word registers.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.AWADDR[1:0], bus.ARADDR[1:0]};

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  // ---------------- write channel ----------------
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) wr_state <= WR_IDLE;
    else          wr_state <= wr_next;
  end

  always_comb begin
    wr_next  = wr_state;
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    b_valid  = 1'b0;
    do_write = 1'b0;
    unique case (wr_state)
      WR_IDLE: begin
        aw_ready = ready_en & ~aw_got;
        w_ready  = ready_en & ~w_got;
        // Commit once both halves are in hand, counting ones arriving now.
        if ((aw_got | (bus.AWVALID & aw_ready)) &
            (w_got  | (bus.WVALID  & w_ready))) begin
          do_write = 1'b1;
          wr_next  = WR_RESP;
        end
      end
      WR_RESP: begin
        b_valid = 1'b1;
        if (bus.BREADY) wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  assign aw_hs = bus.AWVALID & aw_ready;
  assign w_hs  = bus.WVALID  & w_ready;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
    end else if (do_write) begin
      aw_got <= 1'b0;
      w_got  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_got   <= 1'b1;
        awaddr_q <= bus.AWADDR[ADDR_W-1:2];
      end
      if (w_hs) begin
        w_got   <= 1'b1;
        wdata_q <= bus.WDATA;
      end
    end
  end

  // Use the live bus value for whichever half completes on the commit edge.
  assign reg_waddr = aw_hs ? bus.AWADDR[ADDR_W-1:2] : awaddr_q;
  assign reg_wdata = w_hs  ? bus.WDATA              : wdata_q;

  assign bus.AWREADY = aw_ready;
  assign bus.WREADY  = w_ready;
  assign bus.BVALID  = b_valid;
  assign bus.BRESP   = RESP_OKAY;

  // ---------------- read channel ----------------
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) rd_state <= RD_IDLE;
    else          rd_state <= rd_next;
  end

  always_comb begin
    rd_next  = rd_state;
    ar_ready = 1'b0;
    r_valid  = 1'b0;
    unique case (rd_state)
      RD_IDLE: begin
        ar_ready = ready_en;
        if (bus.ARVALID & ar_ready) rd_next = RD_DATA;
      end
      RD_DATA: begin
        r_valid = 1'b1;
        if (bus.RREADY) rd_next = RD_IDLE;
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  assign ar_hs = bus.ARVALID & ar_ready;

  // Captured from the combinational port, so a same-edge write is not seen.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)   bus.RDATA <= '0;
    else if (ar_hs) bus.RDATA <= reg_rdata;
  end

  assign bus.ARREADY = ar_ready;
  assign bus.RVALID  = r_valid;
  assign bus.RRESP   = RESP_OKAY;

  axi4_lite_regfile u_regfile (
    .clk   (ACLK),
    .rst_n (ARESETn),
    .we    (do_write),
    .waddr (reg_waddr),
    .wdata (reg_wdata),
    .raddr (bus.ARADDR[ADDR_W-1:2]),
    .rdata (reg_rdata),
    .regs  (regs)
  );

  assign slv_reg0 = regs[0];
  assign slv_reg1 = regs[1];
  assign slv_reg2 = regs[2];
  assign slv_reg3 = regs[3];

  assign wr_state_dbg = wr_state;
  assign rd_state_dbg = rd_state;
endmodule

// File: tb/tb_axi4_lite_slave.sv
// Bench for axi4_lite_slave: directed scenarios followed by random traffic,
// checked against a word-array model of the register bank.
module tb_axi4_lite_slave;
  import axi4_lite_pkg::*;

  localparam int TMO = 40;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [31:0] slv_reg0, slv_reg1, slv_reg2, slv_reg3;
  wr_state_e   wr_state_dbg;
  rd_state_e   rd_state_dbg;

  axi4_lite_slave_if bus();

  axi4_lite_slave dut (
    .ACLK         (ACLK),
    .ARESETn      (ARESETn),
    .bus          (bus),
    .slv_reg0     (slv_reg0),
    .slv_reg1     (slv_reg1),
    .slv_reg2     (slv_reg2),
    .slv_reg3     (slv_reg3),
    .wr_state_dbg (wr_state_dbg),
    .rd_state_dbg (rd_state_dbg)
  );

  // ---------------- clock ----------------
  always #5 ACLK = ~ACLK;

  // ---------------- scoreboard ----------------
  int          n_asserts = 0;
  int          n_fail    = 0;
  logic [31:0] model [4];

  function automatic logic [31:0] reg_out(input int i);
    case (i)
      0:       return slv_reg0;
      1:       return slv_reg1;
      2:       return slv_reg2;
      default: return slv_reg3;
    endcase
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 4; i++)
      chk32($sformatf("%s_slv_reg%0d", tag, i), reg_out(i), model[i]);
  endtask

  // ---------------- drivers (called and returning at a falling edge) -------
  task automatic do_write(input logic [3:0] a, input logic [31:0] d,
                          input int aw_dly, input int w_dly, input int b_hold,
                          input bit chk_no_early_b);
    fork
      begin
        int cnt = 0;
        repeat (aw_dly) @(negedge ACLK);
        bus.AWADDR  = a;
        bus.AWVALID = 1'b1;
        while (bus.AWREADY !== 1'b1 && cnt < TMO) begin
          @(negedge ACLK);
          cnt++;
        end
        chk1("aw_accept", cnt < TMO, 1'b1);
        @(negedge ACLK);
        bus.AWVALID = 1'b0;
      end
      begin
        int cnt = 0;
        repeat (w_dly) @(negedge ACLK);
        bus.WDATA  = d;
        bus.WVALID = 1'b1;
        while (bus.WREADY !== 1'b1 && cnt < TMO) begin
          @(negedge ACLK);
          cnt++;
        end
        chk1("w_accept", cnt < TMO, 1'b1);
        @(negedge ACLK);
        bus.WVALID = 1'b0;
      end
      begin
        if (chk_no_early_b) begin
          repeat (aw_dly) begin
            @(negedge ACLK);
            chk1("no_early_bvalid", bus.BVALID, 1'b0);
          end
        end
      end
    join
    // Both halves landed on the previous rising edge: response must be up.
    model[a[3:2]] = d;
    chk1("bvalid_latency", bus.BVALID, 1'b1);
    chk32("bresp", 32'(bus.BRESP), 32'(RESP_OKAY));
    chk1("awready_in_resp", bus.AWREADY, 1'b0);
    chk1("wready_in_resp", bus.WREADY, 1'b0);
    check_all_regs("after_write");
    repeat (b_hold) begin
      @(negedge ACLK);
      chk1("bvalid_hold", bus.BVALID, 1'b1);
      chk1("awready_hold", bus.AWREADY, 1'b0);
      chk1("wready_hold", bus.WREADY, 1'b0);
    end
    bus.BREADY = 1'b1;
    @(negedge ACLK);
    bus.BREADY = 1'b0;
    chk1("bvalid_clear", bus.BVALID, 1'b0);
    chk1("awready_back", bus.AWREADY, 1'b1);
  endtask

  task automatic do_read(input logic [3:0] a, input logic [31:0] exp, input int r_hold);
    int cnt = 0;
    bus.ARADDR  = a;
    bus.ARVALID = 1'b1;
    while (bus.ARREADY !== 1'b1 && cnt < TMO) begin
      @(negedge ACLK);
      cnt++;
    end
    chk1("ar_accept", cnt < TMO, 1'b1);
    @(negedge ACLK);
    bus.ARVALID = 1'b0;
    chk1("rvalid_latency", bus.RVALID, 1'b1);
    chk32("rdata", bus.RDATA, exp);
    chk32("rresp", 32'(bus.RRESP), 32'(RESP_OKAY));
    chk1("arready_in_data", bus.ARREADY, 1'b0);
    repeat (r_hold) begin
      @(negedge ACLK);
      chk1("rvalid_hold", bus.RVALID, 1'b1);
      chk32("rdata_stable", bus.RDATA, exp);
    end
    bus.RREADY = 1'b1;
    @(negedge ACLK);
    bus.RREADY = 1'b0;
    chk1("rvalid_clear", bus.RVALID, 1'b0);
    chk1("arready_back", bus.ARREADY, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0]  wa, ra;
    logic [31:0] wd, rexp;
    int          op;

    bus.AWADDR = '0; bus.AWVALID = 1'b0;
    bus.WDATA  = '0; bus.WVALID  = 1'b0; bus.BREADY = 1'b0;
    bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = '0;

    // Reset and its output values.
    ARESETn = 1'b1;
    #1 ARESETn = 1'b0;
    repeat (3) @(negedge ACLK);
    chk1("rst_awready", bus.AWREADY, 1'b0);
    chk1("rst_wready", bus.WREADY, 1'b0);
    chk1("rst_arready", bus.ARREADY, 1'b0);
    chk1("rst_bvalid", bus.BVALID, 1'b0);
    chk1("rst_rvalid", bus.RVALID, 1'b0);
    chk32("rst_rdata", bus.RDATA, 32'h0);
    chk32("rst_wr_state", 32'(wr_state_dbg), 32'(WR_IDLE));
    chk32("rst_rd_state", 32'(rd_state_dbg), 32'(RD_IDLE));
    check_all_regs("rst");
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk1("post_rst_awready", bus.AWREADY, 1'b1);
    chk1("post_rst_wready", bus.WREADY, 1'b1);
    chk1("post_rst_arready", bus.ARREADY, 1'b1);

    // AW and W on the same edge.
    do_write(4'h4, 32'hDEADBEEF, 0, 0, 0, 1'b0);
    // W first, AW three edges later; no response before AW.
    do_write(4'hC, 32'h12345678, 3, 0, 0, 1'b1);
    // Master stalls the write response for five cycles.
    do_write(4'h8, 32'h0BADF00D, 1, 2, 5, 1'b0);
    do_write(4'h0, 32'h00C0FFEE, 0, 1, 0, 1'b0);

    // Byte offset ignored; RDATA held while RREADY is low.
    do_write(4'h4, 32'hA5A5A5A5, 0, 0, 0, 1'b0);
    do_read(4'h7, model[1], 3);

    // Same-edge read and write of reg0: old value comes back.
    do_write(4'h0, 32'h0, 0, 0, 0, 1'b0);
    rexp = model[0];
    fork
      do_write(4'h0, 32'h00000001, 0, 0, 0, 1'b0);
      do_read(4'h0, rexp, 1);
    join
    chk32("same_edge_reg0", slv_reg0, 32'h00000001);

    // Reset while both channels hold a response.
    bus.AWADDR = 4'h8; bus.WDATA = 32'h55AA55AA; bus.ARADDR = 4'h8;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.ARVALID = 1'b1;
    @(negedge ACLK);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    chk1("pre_rst_bvalid", bus.BVALID, 1'b1);
    chk1("pre_rst_rvalid", bus.RVALID, 1'b1);
    chk32("pre_rst_slv_reg2", slv_reg2, 32'h55AA55AA);
    #2 ARESETn = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) model[i] = '0;
    chk1("mid_rst_bvalid", bus.BVALID, 1'b0);
    chk1("mid_rst_rvalid", bus.RVALID, 1'b0);
    chk1("mid_rst_awready", bus.AWREADY, 1'b0);
    chk1("mid_rst_arready", bus.ARREADY, 1'b0);
    chk32("mid_rst_rdata", bus.RDATA, 32'h0);
    check_all_regs("mid_rst");
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk1("rst2_bvalid", bus.BVALID, 1'b0);
    chk1("rst2_rvalid", bus.RVALID, 1'b0);
    do_write(4'h8, 32'hCAFEF00D, 0, 0, 0, 1'b0);
    do_read(4'hA, model[2], 0);

    // Random traffic.
    for (int n = 0; n < 30; n++) begin
      op = $urandom_range(0, 2);
      wa = 4'($urandom_range(0, 15));
      ra = 4'($urandom_range(0, 15));
      wd = $urandom;
      if (op == 0) begin
        do_write(wa, wd, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
      end else if (op == 1) begin
        do_read(ra, model[ra[3:2]], $urandom_range(0, 3));
      end else begin
        rexp = model[ra[3:2]];
        fork
          do_write(wa, wd, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
          do_read(ra, rexp, $urandom_range(0, 2));
        join
      end
    end
    check_all_regs("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  // Guard against any unbounded stall.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end
endmodule

// File: doc/axi4_lite_slave.md
# axi4_lite_slave

AXI4-Lite slave with a bank of four 32-bit read/write registers. It sits directly downstream of the team's AXI4-Lite master and terminates its AW, W, B, AR and R channels. It decodes a 4-bit byte address into a word index and exposes every register contents to fabric logic in parallel.

## Interface
Parameters:
- ADDR_W, 4: AXI address width; bits [3:2] select the register, bits [1:0] are ignored.
- DATA_W, 32: register and data-bus width.
- NUM_REGS, 4: register count; fixed at 2^(ADDR_W-2).

Ports:
- ACLK  in  1  single clock; all logic on its rising edge.
- ARESETn  in  1  reset; asynchronous and active-low.
- AWADDR  in  4  write address.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WDATA  in  32  write data.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BRESP  out  2  write response; always 2'b00 (OKAY).
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- ARADDR  in  4  read address.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RDATA  out  32  read data.
- RRESP  out  2  read response; always 2'b00 (OKAY).
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.
- slv_reg0..slv_reg3  out  32 each  current register contents.

## Operation
- A handshake completes on a rising edge where VALID and READY are both high. READY never depends combinationally on VALID.
- The write FSM has two states: WR_IDLE and WR_RESP.
- In WR_IDLE:
  - AWREADY = !aw_got and WREADY = !w_got.
  - An AW handshake latches AWADDR and sets aw_got.
  - A W handshake latches WDATA and sets w_got.
  - AW and W handshakes are accepted in either order or on the same edge.
- WR_IDLE -> WR_RESP on the edge where (aw_got | AW handshake) & (w_got | W handshake). On that same edge:
  - the addressed register is written;
  - aw_got and w_got are cleared.
- In WR_RESP: BVALID=1, BRESP=2'b00, AWREADY=WREADY=0. It returns to WR_IDLE on the edge where BREADY=1.
- The read FSM has two states: RD_IDLE and RD_DATA.
- In RD_IDLE: ARREADY=1. On an AR handshake, RDATA <= reg[ARADDR[3:2]] and the FSM goes to RD_DATA.
- In RD_DATA: RVALID=1, RRESP=2'b00, ARREADY=0. RDATA is held stable. It returns to RD_IDLE on the edge where RREADY=1.
- The read and write FSMs are independent and may be active in the same cycle.
- A read and a write to the same register on the same edge: the read returns the old value, and the write takes effect.
- All four addresses are mapped, so no SLVERR is ever issued.

## Timing
- Reset (ARESETn=0, asynchronous) forces:
  - both FSMs to their idle states;
  - aw_got=w_got=0;
  - all registers, RDATA, BRESP and RRESP to 0;
  - AWREADY, WREADY, ARREADY, BVALID and RVALID to 0.
- After reset deasserts, ready signals rise in the first cycle.
- Reset mid-transaction abandons the transaction. No B or R response is produced for it.
- Write latency: when AW and W complete on edge N, the register and slv_regN update at N, and BVALID is high after N.
- Read latency: when AR completes on edge N, RVALID and RDATA are valid after N.
- Throughput is one write per 2 cycles and one read per 2 cycles when BREADY/RREADY are held high.
- BVALID and RVALID, once high, stay high until their handshake.

## Structure
- Package axi4_lite_pkg holds:
  - ADDR_W and DATA_W;
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - enums wr_state_e {WR_IDLE, WR_RESP} and rd_state_e {RD_IDLE, RD_DATA}.
- The master shares this package.
- The register bank is a sub-module, axi4_lite_regfile. It holds 4x32 flops with one synchronous write port (we, waddr[1:0], wdata), one combinational read port (raddr[1:0] -> rdata) and parallel outputs.
- The top level holds only the channel FSMs.

## Test plan
- Reset, then write 0xDEADBEEF to addr 0x4 with AW and W on the same edge -> AWREADY/WREADY drop, BVALID=1 with BRESP=00 the next cycle, slv_reg1=0xDEADBEEF.
- W on edge N and AW on edge N+3, data 0x12345678 to addr 0xC -> no BVALID until after N+3, then slv_reg3=0x12345678.
- Hold BREADY=0 for 5 cycles -> BVALID stays 1, AWREADY=WREADY=0; when BREADY rises, the FSM returns to WR_IDLE and the next write is accepted.
- Read addr 0x7 after writing 0xA5A5A5A5 to 0x4 -> RDATA=0xA5A5A5A5 and RRESP=00; with RREADY held low for 3 cycles, RDATA stays stable.
- Read and write 0x00000001 to addr 0x0 on the same edge, with reg0=0 beforehand -> RDATA=0, and slv_reg0=1 afterwards.
- Assert ARESETn=0 while in WR_RESP and RD_DATA -> BVALID=RVALID=0 immediately and all slv_reg=0; after release, a new write completes normally.
